// File: rtl/seg7_scan6_if.sv
// Bundle between the hh:mm:ss timer / display pins and the six-digit scan driver.
interface seg7_scan6_if;
  logic [23:0] digits;
  logic [5:0]  dp_mask;
  logic        blank_lz;
  logic [6:0]  seg;
  logic        dp;
  logic [5:0]  sel;
  logic        frame_start;

  modport master (
    output digits, dp_mask, blank_lz,
    input  seg, dp, sel, frame_start
  );

  modport slave (
    input  digits, dp_mask, blank_lz,
    output seg, dp, sel, frame_start
  );
endinterface

// File: rtl/seg7_scan6.sv
// Six-digit multiplexed 7-seg scanner: per-frame snapshot of packed BCD,
// blank-then-show slot per digit, optional leading-zero suppression.
module seg7_scan6_lane (
  input  logic [3:0] nib_snap,
  input  logic [3:0] nib_in,
  output logic [6:0] pat,
  output logic       zero_in
);
  always_comb begin
    pat = 7'h40;
    case (nib_snap)
      4'd0: pat = 7'h3F;
      4'd1: pat = 7'h06;
      4'd2: pat = 7'h5B;
      4'd3: pat = 7'h4F;
      4'd4: pat = 7'h66;
      4'd5: pat = 7'h6D;
      4'd6: pat = 7'h7D;
      4'd7: pat = 7'h07;
      4'd8: pat = 7'h7F;
      4'd9: pat = 7'h6F;
      default: pat = 7'h40;
    endcase
  end

  // Zero detect looks at the live input: it feeds the blank flags captured in LOAD.
  assign zero_in = (nib_in == 4'd0);
endmodule

module seg7_scan6 #(
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYC      = 500,
  parameter int ACTIVE_LOW_SEG = 1,
  parameter int ACTIVE_LOW_SEL = 1
) (
  input  logic        clk,
  input  logic        rst,
  seg7_scan6_if.slave bus
);
  localparam int NUM_LANES = 6;
  localparam int CW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - BLANK_CYC - 1);
  localparam logic [6:0]    SEG_INV    = (ACTIVE_LOW_SEG != 0) ? 7'h7F : 7'h00;
  localparam logic          DP_INV     = (ACTIVE_LOW_SEG != 0);
  localparam logic [5:0]    SEL_INV    = (ACTIVE_LOW_SEL != 0) ? 6'h3F : 6'h00;

  typedef enum logic [1:0] {LOAD, BLANK, SHOW} state_t;

  state_t                         state, state_n;
  logic [2:0]                     idx, idx_n;
  logic [CW-1:0]                  cnt, cnt_n;
  logic [NUM_LANES-1:0][3:0]      snap_d, snap_d_n;
  logic [NUM_LANES-1:0]           snap_dp, snap_dp_n;
  logic [NUM_LANES-1:0]           blank, blank_n;

  logic [NUM_LANES-1:0][6:0]      pat;
  logic [NUM_LANES-1:0]           zero_in;
  logic [NUM_LANES-1:0][3:0]      digits_in;

  logic [6:0] seg_q, seg_n;
  logic       dp_q, dp_n;
  logic [5:0] sel_q, sel_n;
  logic       fs_q, fs_n;

  assign digits_in = bus.digits;

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      seg7_scan6_lane u_lane (
        .nib_snap (snap_d[g]),
        .nib_in   (digits_in[g]),
        .pat      (pat[g]),
        .zero_in  (zero_in[g])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= LOAD;
      idx     <= '0;
      cnt     <= '0;
      snap_d  <= '0;
      snap_dp <= '0;
      blank   <= '0;
      seg_q   <= SEG_INV;
      dp_q    <= DP_INV;
      sel_q   <= SEL_INV;
      fs_q    <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      cnt     <= cnt_n;
      snap_d  <= snap_d_n;
      snap_dp <= snap_dp_n;
      blank   <= blank_n;
      seg_q   <= seg_n;
      dp_q    <= dp_n;
      sel_q   <= sel_n;
      fs_q    <= fs_n;
    end
  end

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    cnt_n     = cnt;
    snap_d_n  = snap_d;
    snap_dp_n = snap_dp;
    blank_n   = blank;
    case (state)
      LOAD: begin
        snap_d_n  = bus.digits;
        snap_dp_n = bus.dp_mask;
        // Blanking walks down from the leftmost digit until the first nonzero.
        blank_n[NUM_LANES-1] = bus.blank_lz & zero_in[NUM_LANES-1];
        for (int i = NUM_LANES - 2; i >= 1; i--)
          blank_n[i] = blank_n[i+1] & zero_in[i];
        blank_n[0] = 1'b0;
        idx_n   = '0;
        cnt_n   = '0;
        state_n = BLANK;
      end
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          cnt_n   = '0;
          state_n = SHOW;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      SHOW: begin
        if (cnt == SHOW_LAST) begin
          cnt_n = '0;
          if (idx == 3'd5) begin
            state_n = LOAD;
          end else begin
            idx_n   = idx + 3'd1;
            state_n = BLANK;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = LOAD;
    endcase
  end

  // Outputs are derived from the state being entered so they land on that edge.
  // Entering SHOW never coincides with a snapshot update, so snap_d/blank are current.
  always_comb begin
    seg_n = SEG_INV;
    dp_n  = DP_INV;
    sel_n = SEL_INV;
    fs_n  = (state == LOAD);
    if (state_n == SHOW) begin
      sel_n = (6'd1 << idx_n) ^ SEL_INV;
      if (!blank[idx_n]) begin
        seg_n = pat[idx_n] ^ SEG_INV;
        dp_n  = snap_dp[idx_n] ^ DP_INV;
      end
    end
  end

  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.sel         = sel_q;
  assign bus.frame_start = fs_q;
endmodule

// File: doc/seg7_scan6.md
# seg7_scan6

Multiplexed six-digit seven-segment display driver that sits directly downstream of the hh:mm:ss timer. It takes the timer's 24-bit packed BCD word and scans one digit at a time onto a common-segment, per-digit-select display. Each digit slot begins with an anti-ghosting blank interval. The input is snapshotted once per frame, so a timer update mid-scan never produces a torn display.

## Interface
- SCAN_DIV, 50000: cycles per digit slot (1 ms at 50 MHz); must be > BLANK_CYC.
- BLANK_CYC, 500: cycles at slot start with all selects inactive; must be ≥ 1.
- ACTIVE_LOW_SEG, 1: 1 = seg/dp outputs inverted (0 lights a segment).
- ACTIVE_LOW_SEL, 1: 1 = sel outputs inverted (0 enables a digit).
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- digits  in  24  packed BCD; [3:0] = digit 0 (seconds units, rightmost) … [23:20] = digit 5 (leftmost).
- dp_mask  in  6  decimal-point enable per digit, bit i ↔ digit i.
- blank_lz  in  1  1 = blank leading zeros.
- seg  out  7  {g,f,e,d,c,b,a}.
- dp  out  1  decimal point of the selected digit.
- sel  out  6  digit enables, bit i ↔ digit i.
- frame_start  out  1  one-cycle pulse per snapshot.

## Operation
- FSM states: LOAD, BLANK, SHOW; digit index idx is 0..5; cycle counter cnt.
- LOAD, 1 cycle:
  - snap_d ← digits, snap_dp ← dp_mask.
  - Compute blank flags from the new snapshot.
  - idx ← 0, cnt ← 0, frame_start ← 1; go to BLANK.
- BLANK: lasts BLANK_CYC cycles; sel inactive, seg/dp off; then go to SHOW with cnt ← 0.
- SHOW: lasts SCAN_DIV−BLANK_CYC cycles.
  - sel[idx] active, all other sel bits inactive.
  - seg = decode(snap_d[idx]), dp = snap_dp[idx].
  - At end of SHOW: if idx==5 go to LOAD, else idx ← idx+1 and go to BLANK.
- Decode, active-high before polarity: 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F; any nibble A–F → 40 (dash, g only).
- Leading-zero blanking (blank_lz=1):
  - Scan from digit 5 downward; every digit equal to 0 is blanked until the first nonzero digit.
  - Digit 0 is never blanked.
  - A dash digit (A–F) counts as nonzero.
- A blanked digit gets seg off and dp off; sel is still asserted in SHOW, which keeps brightness uniform.
- blank_lz is sampled only in LOAD, as part of the snapshot.
- Polarity parameters invert the final outputs only; all internal logic is active-high.
- Changes on digits, dp_mask and blank_lz between LOAD cycles have no visible effect until the next LOAD.

## Timing
- All outputs are registered and change on the clk edge that enters the corresponding state.
- Reset (rst=0), asynchronous and immediate:
  - state=LOAD, idx=0, cnt=0, snap=0.
  - sel all inactive, seg and dp all off (polarity applied), frame_start=0.
- Reset asserted mid-frame aborts the frame immediately.
- After rst rises:
  - first edge: LOAD executes, and frame_start is high during the following cycle.
  - sel[0] first asserts 1+BLANK_CYC cycles after that edge.
- Frame period: 6·SCAN_DIV+1 cycles. frame_start pulse spacing is exactly this value.
- Digit i SHOW window, measured in cycles after the LOAD edge: starts at 1+i·SCAN_DIV+BLANK_CYC, lasts SCAN_DIV−BLANK_CYC.
- Never more than one sel bit is active; during LOAD and BLANK, zero sel bits are active.
- cnt width: ceil(log2(SCAN_DIV)); cnt never exceeds SCAN_DIV−1.

## Test plan
All scenarios use SCAN_DIV=8, BLANK_CYC=2 and default polarity (frame = 49 cycles).
- Reset release with digits=24'h123456, dp_mask=0, blank_lz=0 → frame_start pulses once. Then sel=6'b111110 for 6 cycles with seg=7'h02 (digit 6), after 2 blank cycles sel=6'b111101 with seg=7'h12 (digit 5), and so on up to digit 5 showing seg=7'h79 (digit 1). frame_start recurs every 49 cycles.
- Mid-frame, change digits to 24'h999999 while digit 2 is in SHOW → the remaining digits of that frame still show 1,2,3. From the next frame on, all digits show seg=7'h10.
- blank_lz=1, digits=24'h000105 → digits 5,4,3 show seg=7'h7F with sel still asserted; digits 2,1,0 show 1,0,5. With digits=0, only digit 0 lights, showing seg=7'h40.
- digits=24'h00000A → digit 0 shows a dash (seg=7'h3F inverted). dp_mask=6'b010100 → dp=0 only during the digit 2 and digit 4 SHOW windows.
- rst pulled low in the middle of a SHOW cycle → in the same cycle, with no clock edge, sel=6'h3F, seg=7'h7F, dp=1. After release, the frame restarts from LOAD.
- Across 3 frames, check every cycle that at most one sel bit is low, and that no sel bit is low during LOAD or BLANK.
